psx_fake_controller: RTL and testbench
======================================

# psx_fake_controller

Emulates a PlayStation digital pad on the PSX serial bus. When the console asserts `att` low and clocks bytes with `psx_clk`, the block shifts out the fixed digital-pad reply, reporting two physical buttons from `d_btn`. It pulses `ack` after each byte except the last. It is the device side of the fake_psx test rig, fed by a console-side source (captured logic-analyzer traffic or a real console).

## Interface
Parameters:
- `ACK_DELAY`, default 8: `clk` cycles from the 8th `psx_clk` rising edge of a byte to `ack` assertion.
- `ACK_WIDTH`, default 16: `clk` cycles `ack` is held low.

Ports:
- `clk`  in  1  system clock; the only clock. Must be ≥ 8× the `psx_clk` frequency.
- `rst`  in  1  reset; synchronous, active-high.
- `psx_clk`  in  1  bus clock from the console; idles high; asynchronous to `clk`.
- `att`  in  1  attention/select from the console; active low; asynchronous.
- `d_btn`  in  2  button inputs, active high; [0] = Cross, [1] = Circle.
- `data`  out  1  open-drain reply line; drives 0 or 'z'.
- `ack`  out  1  open-drain acknowledge; drives 0 or 'z'.

## Operation
- `psx_clk` and `att` pass through 2-flop synchronizers. Edges are detected on the synchronized copies.
- Reply bytes, index 0..4: 0xFF, 0x41 (digital pad ID), 0x5A, 0xFF, BTN.
- BTN = {1, ~d_btn[0], ~d_btn[1], 5'b11111}: bit 6 = Cross, bit 5 = Circle, active low. All other buttons read released.
- `d_btn` is latched on the synchronized `att` falling edge. It is held constant for the whole transaction.
- Bytes are sent LSB first. Each `psx_clk` falling edge presents the next bit.
- `data` = 0 when the current bit is 0, 'z' when it is 1.
- The `cmd` line is not an input. The reply does not depend on console commands.
- States:
  - IDLE: `att` high; outputs 'z'; byte and bit counters zero. Goes to SHIFT on `att` fall.
  - SHIFT: counts `psx_clk` rising edges. On the 8th edge, goes to ACK_WAIT if byte index < 4; otherwise goes to DONE.
  - ACK_WAIT: waits `ACK_DELAY` cycles, then goes to ACK_PULSE.
  - ACK_PULSE: `ack` = 0 for `ACK_WIDTH` cycles. Then increments the byte index and returns to SHIFT.
  - DONE: `data` and `ack` held 'z'. Any further bytes are ignored and get no ack.
- `att` rising in any state: return to IDLE in the next cycle and release both lines. A partial byte is discarded and the next poll restarts at byte 0.
- A `psx_clk` falling edge during ACK_WAIT/ACK_PULSE belongs to the next byte. Its bit 0 is presented, and the ack pulse still completes.

## Timing
- Reset: `data` = 'z', `ack` = 'z', state IDLE, counters 0, latched buttons 0 (released).
- Bit change latency: `data` updates 3 `clk` cycles after the raw `psx_clk` falling edge (2 sync + 1 register). The console samples on the rising edge.
- Ack assertion: `ACK_DELAY` + 3 cycles after the raw 8th rising edge. `ack` stays low exactly `ACK_WIDTH` cycles.
- Abort: outputs release 3 cycles after raw `att` rise.
- Exactly 4 ack pulses per complete 5-byte transaction.

## Structure
- Package `psx_pkg` holds:
  - reply byte constants `PSX_IDLE_BYTE` = 0xFF, `PSX_ID_DIGITAL` = 0x41, `PSX_READY` = 0x5A;
  - `PSX_REPLY_LEN` = 5;
  - button bit positions (`BTN_CROSS` = 6, `BTN_CIRCLE` = 5);
  - the state enum.
- One sub-module `psx_edge_sync`: 2-flop synchronizer plus rise/fall pulse outputs. Instantiated for `psx_clk` and `att`.
- Top level holds the FSM, counters, the reply mux and the open-drain drivers.

## Test plan
- Reset held, then released with `att` high -> `data` and `ack` 'z'; no activity on toggling `psx_clk`.
- Full 5-byte poll, `d_btn` = 00 -> bytes FF, 41, 5A, FF, FF sampled on rising edges. 4 `ack` pulses, each exactly `ACK_WIDTH` cycles, none after byte 4.
- Poll with `d_btn` = 01 -> byte 4 = 0xBF. With `d_btn` = 11 -> 0x9F. With `d_btn` = 10 -> 0xDF.
- Change `d_btn` mid-transaction -> byte 4 reflects the value latched at `att` fall.
- Raise `att` after 3 bits of byte 2 -> both lines 'z' within 3 cycles. Next poll returns FF, 41, … from byte 0.
- Clock 7 bytes -> bytes 5–6 read as FF (line released) with no ack. Assert `rst` mid-byte -> outputs 'z' and state IDLE next cycle.

Source files
------------

// File: rtl/psx_pkg.sv
// Shared constants, FSM state type and reply-byte lookup for the fake PSX digital pad.
package psx_pkg;

  localparam logic [7:0] PSX_IDLE_BYTE  = 8'hFF;
  localparam logic [7:0] PSX_ID_DIGITAL = 8'h41;
  localparam logic [7:0] PSX_READY      = 8'h5A;
  localparam int         PSX_REPLY_LEN  = 5;
  localparam int         BTN_CROSS      = 6;
  localparam int         BTN_CIRCLE     = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_ACK_WAIT,
    ST_ACK_PULSE,
    ST_DONE
  } psx_state_t;

  // Buttons are active high on the pins but active low on the bus.
  function automatic logic [7:0] psx_reply_byte(input logic [2:0] idx, input logic [1:0] btn);
    logic [7:0] b;
    b = PSX_IDLE_BYTE;
    case (idx)
      3'd1: b = PSX_ID_DIGITAL;
      3'd2: b = PSX_READY;
      3'd4: begin
        b[BTN_CROSS]  = ~btn[0];
        b[BTN_CIRCLE] = ~btn[1];
      end
      default: b = PSX_IDLE_BYTE;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/psx_edge_sync.sv
// 2-flop synchronizer with single-cycle rise/fall pulses on the synchronized level.
// Pulses appear 2 cycles after the raw edge; no backpressure.
module psx_edge_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic [1:0] r_sync;
  logic       r_prev;

  // Both bus lines idle high, so reset to 1 to avoid a spurious edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= 2'b11;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], i_async};
      r_prev <= r_sync[1];
    end
  end

  assign o_rise = r_sync[1] & ~r_prev;
  assign o_fall = ~r_sync[1] & r_prev;

endmodule

// File: rtl/psx_fake_controller.sv
// Device side of a PSX digital pad: shifts the fixed 5-byte reply LSB first and acks bytes 0..3.
// data follows psx_clk fall by 3 clk; ack lands ACK_DELAY+3 after the 8th rise; no backpressure.
module psx_fake_controller
  import psx_pkg::*;
#(
  parameter int ACK_DELAY = 8,
  parameter int ACK_WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       psx_clk,
  input  logic       att,
  input  logic [1:0] d_btn,
  output logic       data,
  output logic       ack
);

  localparam int            TMAX       = (ACK_DELAY > ACK_WIDTH) ? ACK_DELAY : ACK_WIDTH;
  localparam int            TW         = $clog2(TMAX + 1);
  localparam logic [TW-1:0] DELAY_LAST = TW'(ACK_DELAY - 1);
  localparam logic [TW-1:0] WIDTH_LAST = TW'(ACK_WIDTH - 1);

  logic w_pclk_rise, w_pclk_fall, w_att_rise, w_att_fall;

  psx_edge_sync u_sync_pclk (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_async(psx_clk),
    .o_rise (w_pclk_rise),
    .o_fall (w_pclk_fall)
  );

  psx_edge_sync u_sync_att (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_async(att),
    .o_rise (w_att_rise),
    .o_fall (w_att_fall)
  );

  psx_state_t    r_state,    w_state_nxt;
  logic [TW-1:0] r_timer,    w_timer_nxt;
  logic [2:0]    r_bit_cnt,  w_bit_cnt_nxt;
  logic [2:0]    r_byte_idx, w_byte_idx_nxt;
  logic [2:0]    r_tx_byte,  w_tx_byte_nxt;
  logic [2:0]    r_tx_bit,   w_tx_bit_nxt;
  logic [1:0]    r_btn,      w_btn_nxt;
  logic          r_data_low, w_data_low_nxt;
  logic          r_ack_low;
  logic [7:0]    w_tx_val;

  // The presentation pointer runs on falling edges independently of the ack
  // handshake, so a fall during ACK_WAIT/ACK_PULSE already serves the next byte.
  assign w_tx_val = psx_reply_byte(r_tx_byte, r_btn);

  always_comb begin
    w_state_nxt    = r_state;
    w_timer_nxt    = r_timer;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_byte_idx_nxt = r_byte_idx;
    w_tx_byte_nxt  = r_tx_byte;
    w_tx_bit_nxt   = r_tx_bit;
    w_btn_nxt      = r_btn;
    w_data_low_nxt = r_data_low;

    if (w_pclk_fall && (r_state inside {ST_SHIFT, ST_ACK_WAIT, ST_ACK_PULSE})) begin
      w_data_low_nxt = ~w_tx_val[r_tx_bit];
      w_tx_bit_nxt   = r_tx_bit + 3'd1;
      if (r_tx_bit == 3'd7 && r_tx_byte < 3'(PSX_REPLY_LEN))
        w_tx_byte_nxt = r_tx_byte + 3'd1;
    end

    case (r_state)
      ST_IDLE: begin
        if (w_att_fall) begin
          w_state_nxt = ST_SHIFT;
          w_btn_nxt   = d_btn;
        end
      end
      ST_SHIFT: begin
        if (w_pclk_rise) begin
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            w_bit_cnt_nxt = 3'd0;
            w_timer_nxt   = '0;
            w_state_nxt   = (r_byte_idx < 3'(PSX_REPLY_LEN - 1)) ? ST_ACK_WAIT : ST_DONE;
          end
        end
      end
      ST_ACK_WAIT: begin
        if (r_timer == DELAY_LAST) begin
          w_timer_nxt = '0;
          w_state_nxt = ST_ACK_PULSE;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      ST_ACK_PULSE: begin
        if (r_timer == WIDTH_LAST) begin
          w_timer_nxt    = '0;
          w_byte_idx_nxt = r_byte_idx + 3'd1;
          w_state_nxt    = ST_SHIFT;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      ST_DONE: w_data_low_nxt = 1'b0;
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_att_rise)
      w_state_nxt = ST_IDLE;

    if (w_state_nxt == ST_IDLE) begin
      w_timer_nxt    = '0;
      w_bit_cnt_nxt  = 3'd0;
      w_byte_idx_nxt = 3'd0;
      w_tx_byte_nxt  = 3'd0;
      w_tx_bit_nxt   = 3'd0;
    end
    if (w_state_nxt == ST_IDLE || w_state_nxt == ST_DONE)
      w_data_low_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_timer    <= '0;
      r_bit_cnt  <= 3'd0;
      r_byte_idx <= 3'd0;
      r_tx_byte  <= 3'd0;
      r_tx_bit   <= 3'd0;
      r_btn      <= 2'b00;
      r_data_low <= 1'b0;
      r_ack_low  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_byte_idx <= w_byte_idx_nxt;
      r_tx_byte  <= w_tx_byte_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_btn      <= w_btn_nxt;
      r_data_low <= w_data_low_nxt;
      r_ack_low  <= (w_state_nxt == ST_ACK_PULSE);
    end
  end

  assign data = r_data_low ? 1'b0 : 1'bz;
  assign ack  = r_ack_low  ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_psx_fake_controller.sv
// Directed bench for psx_fake_controller: console-side bit-banging with a byte/ack scoreboard.
module tb_psx_fake_controller;

  localparam int ACK_DELAY = 8;
  localparam int ACK_WIDTH = 16;
  localparam int HALF      = 10;
  localparam int ACK_WIN   = 40;

  typedef struct {
    logic [7:0] dat;
    int         ack_first;
    int         ack_lows;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic       clk = 1'b0;
  logic       rst;
  logic       psx_clk;
  logic       att;
  logic [1:0] d_btn;
  tri1        data_w;
  tri1        ack_w;

  psx_fake_controller #(
    .ACK_DELAY(ACK_DELAY),
    .ACK_WIDTH(ACK_WIDTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .psx_clk(psx_clk),
    .att    (att),
    .d_btn  (d_btn),
    .data   (data_w),
    .ack    (ack_w)
  );

  always #5 clk = ~clk;

  function automatic int lvl(input logic v);
    return (v === 1'b0) ? 0 : 1;
  endfunction

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Console view: falls present bits, the line is sampled just before each rise.
  task automatic shift_bits(input int n, output logic [7:0] got);
    got = 8'h00;
    for (int b = 0; b < n; b++) begin
      psx_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      got = {(data_w === 1'b0) ? 1'b0 : 1'b1, got[7:1]};
      psx_clk = 1'b1;
      if (b < n - 1) repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic clock_byte(input string tag);
    logic [7:0] got;
    int         first;
    int         lows;
    exp_t       e;
    shift_bits(8, got);
    first = 0;
    lows  = 0;
    for (int k = 1; k <= ACK_WIN; k++) begin
      @(negedge clk);
      if (ack_w === 1'b0) begin
        lows++;
        if (first == 0) first = k;
      end
    end
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard empty observed=%0h", tag, got);
    end else begin
      e = exp_q.pop_front();
      check({tag, " byte"}, int'(got), int'(e.dat));
      check({tag, " ack_start"}, first, e.ack_first);
      check({tag, " ack_len"}, lows, e.ack_lows);
    end
  endtask

  task automatic expect_poll(input logic [7:0] byte4, input int nbytes);
    exp_t e;
    for (int i = 0; i < nbytes; i++) begin
      case (i)
        1:       e.dat = 8'h41;
        2:       e.dat = 8'h5A;
        4:       e.dat = byte4;
        default: e.dat = 8'hFF;
      endcase
      e.ack_first = (i < 4) ? ACK_DELAY + 3 : 0;
      e.ack_lows  = (i < 4) ? ACK_WIDTH : 0;
      exp_q.push_back(e);
    end
  endtask

  task automatic poll(input string tag, input logic [1:0] btn, input logic [7:0] byte4,
                      input int nbytes, input logic [1:0] btn_mid);
    d_btn = btn;
    expect_poll(byte4, nbytes);
    att = 1'b0;
    repeat (HALF) @(negedge clk);
    d_btn = btn_mid;
    for (int i = 0; i < nbytes; i++) clock_byte($sformatf("%s b%0d", tag, i));
    repeat (HALF) @(negedge clk);
    att = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  initial begin
    logic [7:0] got;
    int         lows;

    rst = 1'b1; att = 1'b1; psx_clk = 1'b1; d_btn = 2'b00;
    repeat (5) @(negedge clk);
    check("reset data", lvl(data_w), 1);
    check("reset ack", lvl(ack_w), 1);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    lows = 0;
    for (int i = 0; i < 16; i++) begin
      psx_clk = ~psx_clk;
      repeat (HALF) begin
        @(negedge clk);
        if (data_w === 1'b0 || ack_w === 1'b0) lows++;
      end
    end
    check("idle quiet", lows, 0);

    poll("p00", 2'b00, 8'hFF, 5, 2'b00);
    poll("p01", 2'b01, 8'hBF, 5, 2'b01);
    poll("p11", 2'b11, 8'h9F, 5, 2'b11);
    poll("p10", 2'b10, 8'hDF, 5, 2'b10);
    poll("midchg", 2'b01, 8'hBF, 5, 2'b10);

    // Abort after 3 bits of byte 2 (0x5A: bits 0,1,2 = 0,1,0).
    d_btn = 2'b00;
    expect_poll(8'hFF, 2);
    att = 1'b0;
    repeat (HALF) @(negedge clk);
    clock_byte("abort b0");
    clock_byte("abort b1");
    shift_bits(3, got);
    check("abort bits", int'(got[7:5]), 3'b010);
    check("abort pre data", lvl(data_w), 0);
    att = 1'b1;
    repeat (2) @(negedge clk);
    check("abort data held", lvl(data_w), 0);
    @(negedge clk);
    check("abort data rel", lvl(data_w), 1);
    check("abort ack rel", lvl(ack_w), 1);
    repeat (2 * HALF) @(negedge clk);
    poll("postabort", 2'b00, 8'hFF, 5, 2'b00);

    poll("seven", 2'b11, 8'h9F, 7, 2'b11);

    // Reset mid byte 1 (0x41: bits 0,1,2 = 1,0,0).
    d_btn = 2'b00;
    expect_poll(8'hFF, 1);
    att = 1'b0;
    repeat (HALF) @(negedge clk);
    clock_byte("rstmid b0");
    shift_bits(3, got);
    check("rstmid pre data", lvl(data_w), 0);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid data", lvl(data_w), 1);
    check("rstmid ack", lvl(ack_w), 1);
    att = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (2 * HALF) @(negedge clk);
    poll("postrst", 2'b10, 8'hDF, 5, 2'b10);

    check("scoreboard drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
